// File: rtl/au_nibble_serial_pkg.sv
// Shared definitions for the nibble-serial arithmetic sequencer.
// Contents: op codes, FSM state codes, nibble width and the B-operand
// select function used by the per-nibble AU_4 datapath.
package au_nibble_serial_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,  // A + B + Cin
    OP_ADDNB = 2'b01,  // A + ~B + Cin (subtract when Cin = 1)
    OP_PASS  = 2'b10,  // A + Cin
    OP_DEC   = 2'b11   // A + all-ones + Cin (A - 1 + Cin)
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // B' as seen by the adder for one nibble.
  function automatic logic [NIBBLE_W-1:0] b_prime(input logic [NIBBLE_W-1:0] b,
                                                  input op_e op);
    logic [NIBBLE_W-1:0] r;
    r = b;
    case (op)
      OP_ADD:   r = b;
      OP_ADDNB: r = ~b;
      OP_PASS:  r = '0;
      OP_DEC:   r = '1;
      default:  r = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/au_nibble_serial_au4.sv
// AU_4: 4-bit arithmetic unit, combinational, one nibble per use.
// Ports: a_i/b_i nibble operands, sel_i op select, cin_i carry-in;
//        sum_o nibble sum, cout_o carry-out, bp_msb_o top bit of B' (for overflow).
module au_nibble_serial_au4
  import au_nibble_serial_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  logic [1:0]          sel_i,
  input  logic                cin_i,
  output logic [NIBBLE_W-1:0] sum_o,
  output logic                cout_o,
  output logic                bp_msb_o
);

  logic [NIBBLE_W-1:0] bp;
  logic [NIBBLE_W:0]   full;

  always_comb begin
    bp       = b_prime(b_i, op_e'(sel_i));
    full     = {1'b0, a_i} + {1'b0, bp} + {{NIBBLE_W{1'b0}}, cin_i};
    sum_o    = full[NIBBLE_W-1:0];
    cout_o   = full[NIBBLE_W];
    bp_msb_o = bp[NIBBLE_W-1];
  end

endmodule

// File: rtl/au_nibble_serial.sv
// au_nibble_serial: wide add/subtract built by stepping one AU_4 across the
// operands LSB nibble first, chaining carry between nibbles.
// Ports: i_valid/o_ready accept an op (i_a, i_b, i_op, i_Cin); o_valid/i_ready
//        hand back o_result with o_Cout, o_zero, o_ovf. Result valid NIBBLES
//        cycles after acceptance; held until i_ready.
module au_nibble_serial
  import au_nibble_serial_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0]   i_a,
  input  logic [NIBBLE_W*NIBBLES-1:0]   i_b,
  input  logic [1:0]                    i_op,
  input  logic                          i_Cin,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [NIBBLE_W*NIBBLES-1:0]   o_result,
  output logic                          o_Cout,
  output logic                          o_zero,
  output logic                          o_ovf
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  if (NIBBLES < 2 || NIBBLES > 8) begin : g_bad_param
    $error("au_nibble_serial: NIBBLES must be in 2..8");
  end

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q,   idx_d;
  logic [W-1:0]    a_q,     a_d;
  logic [W-1:0]    b_q,     b_d;
  op_e             op_q,    op_d;
  logic            c_q,     c_d;
  logic [W-1:0]    res_q,   res_d;
  logic            cout_q,  cout_d;
  logic            zero_q,  zero_d;
  logic            ovf_q,   ovf_d;

  logic [NIBBLE_W-1:0] au_a, au_b, au_sum;
  logic                au_cout, au_bp_msb;

  // The datapath only ever sees the current nibble of the latched operands.
  assign au_a = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
  assign au_b = b_q[idx_q*NIBBLE_W +: NIBBLE_W];

  au_nibble_serial_au4 u_au4 (
    .a_i      (au_a),
    .b_i      (au_b),
    .sel_i    (op_q),
    .cin_i    (c_q),
    .sum_o    (au_sum),
    .cout_o   (au_cout),
    .bp_msb_o (au_bp_msb)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      c_q     <= 1'b0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      c_q     <= c_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    c_d     = c_q;
    res_d   = res_q;
    cout_d  = cout_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          a_d     = i_a;
          b_d     = i_b;
          op_d    = op_e'(i_op);
          c_d     = i_Cin;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        res_d[idx_q*NIBBLE_W +: NIBBLE_W] = au_sum;
        c_d   = au_cout;
        idx_d = idx_q + IW'(1);
        if (idx_q == LAST) begin
          // Top nibble: the flags see the fully assembled result, and the
          // sign bits of A, B' and R are all visible in this cycle.
          cout_d  = au_cout;
          zero_d  = (res_d == '0);
          ovf_d   = (a_q[W-1] & au_bp_msb & ~au_sum[NIBBLE_W-1]) |
                    (~a_q[W-1] & ~au_bp_msb & au_sum[NIBBLE_W-1]);
          idx_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // i_valid is deliberately ignored here, even alongside i_ready.
        if (i_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_ready  = (state_q == S_IDLE);
  assign o_valid  = (state_q == S_DONE);
  assign o_result = res_q;
  assign o_Cout   = cout_q;
  assign o_zero   = zero_q;
  assign o_ovf    = ovf_q;

endmodule

// File: tb/tb_au_nibble_serial.sv
module tb_au_nibble_serial;

  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] i_a, i_b;
  logic [1:0]   i_op;
  logic         i_Cin;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_result;
  logic         o_Cout, o_zero, o_ovf;

  au_nibble_serial #(.NIBBLES(NIBBLES)) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_a      (i_a),
    .i_b      (i_b),
    .i_op     (i_op),
    .i_Cin    (i_Cin),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_Cout   (o_Cout),
    .o_zero   (o_zero),
    .o_ovf    (o_ovf)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: whole-word arithmetic straight from the op definitions.
  task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, output logic [W-1:0] r, output logic cout,
                       output logic zero, output logic ovf);
    logic [W-1:0] bp;
    logic [W:0]   full;
    case (op)
      2'b00:   bp = b;
      2'b01:   bp = ~b;
      2'b10:   bp = '0;
      default: bp = '1;
    endcase
    full = {1'b0, a} + {1'b0, bp} + (W+1)'(cin);
    r    = full[W-1:0];
    cout = full[W];
    zero = (r == 0);
    ovf  = (a[W-1] & bp[W-1] & ~r[W-1]) | (~a[W-1] & ~bp[W-1] & r[W-1]);
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 after acceptance.
  task automatic start_op(input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic cin);
    chk("ready_before_accept", o_ready, 1);
    i_op = op; i_a = a; i_b = b; i_Cin = cin; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
  endtask

  // Waits for o_valid, counting edges since acceptance; optionally scrambles inputs.
  task automatic wait_done(input bit scramble);
    int lat = 0;
    while (!o_valid && lat < 50) begin
      if (scramble) begin
        i_a = W'($urandom); i_b = W'($urandom);
        i_op = 2'($urandom); i_Cin = 1'($urandom); i_valid = 1'($urandom);
      end
      @(posedge i_clk); #1;
      lat++;
    end
    i_valid = 1'b0;
    chk("latency", lat, NIBBLES);
    chk("ready_in_done", o_ready, 0);
  endtask

  task automatic check_out(input logic [W-1:0] r, input logic cout,
                           input logic zero, input logic ovf);
    chk("result", o_result, r);
    chk("cout", o_Cout, cout);
    chk("zero", o_zero, zero);
    chk("ovf", o_ovf, ovf);
  endtask

  task automatic ack();
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
    chk("ready_after_ack", o_ready, 1);
    chk("valid_after_ack", o_valid, 0);
  endtask

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         cin;
    logic [W-1:0] r;
    logic         cout, zero, ovf;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [W-1:0] r, lr;
    logic         c, z, v;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         cin;

    vecs[0] = '{2'b00, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{2'b01, 16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{2'b00, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{2'b11, 16'h0000, 16'h1234, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{2'b10, 16'hFFFF, 16'hABCD, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{2'b01, 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{2'b00, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{2'b00, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{2'b01, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b1};
    vecs[9] = '{2'b11, 16'h0005, 16'h0000, 1'b1, 16'h0005, 1'b1, 1'b0, 1'b0};

    i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_a = '0; i_b = '0; i_op = '0; i_Cin = 1'b0;
    #12;
    chk("rst_ready", o_ready, 1);
    chk("rst_valid", o_valid, 0);
    check_out('0, 0, 0, 0);
    @(negedge i_clk); i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin);
      wait_done(1'b0);
      check_out(vecs[i].r, vecs[i].cout, vecs[i].zero, vecs[i].ovf);
      ack();
      chk("hold_in_idle", o_result, vecs[i].r);
    end

    // Backpressure: result stays put while i_valid and operands toggle.
    start_op(2'b00, 16'h1234, 16'h0FFF, 1'b0);
    wait_done(1'b0);
    for (int i = 0; i < 10; i++) begin
      i_valid = 1'($urandom); i_a = W'($urandom); i_b = W'($urandom);
      @(posedge i_clk); #1;
      chk("bp_valid", o_valid, 1);
      chk("bp_ready", o_ready, 0);
      chk("bp_result", o_result, 16'h2233);
    end
    i_valid = 1'b1;  // simultaneous with i_ready: must not be accepted
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0; i_valid = 1'b0;
    chk("bp_release_ready", o_ready, 1);
    chk("bp_release_valid", o_valid, 0);
    @(posedge i_clk); #1;
    chk("no_accept_with_ack", o_ready, 1);
    chk("idle_hold_result", o_result, 16'h2233);

    // Operand stability: inputs churn during RUN.
    start_op(2'b01, 16'h4321, 16'h1111, 1'b1);
    wait_done(1'b1);
    check_out(16'h3210, 1, 0, 0);
    ack();

    // Reset mid-RUN after nibble 1 is written.
    start_op(2'b00, 16'h1111, 16'h2222, 1'b0);
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    chk("running_before_rst", o_ready, 0);
    i_rst_n = 1'b0;
    #1;
    chk("midrst_ready", o_ready, 1);
    chk("midrst_valid", o_valid, 0);
    check_out('0, 0, 0, 0);
    @(negedge i_clk); i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    start_op(2'b00, 16'h00FF, 16'h0001, 1'b0);
    wait_done(1'b0);
    check_out(16'h0100, 0, 0, 0);
    ack();

    // Randomized operations against the model.
    lr = 16'h0100;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom); a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      if (i % 8 == 0) a = W'($urandom_range(0, 3));
      if (i % 8 == 1) b = a;
      model(op, a, b, cin, r, c, z, v);
      chk("rand_idle_hold", o_result, lr);
      start_op(op, a, b, cin);
      wait_done(i[0]);
      check_out(r, c, z, v);
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
        @(posedge i_clk); #1;
        chk("rand_hold_valid", o_valid, 1);
      end
      ack();
      lr = r;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
